// File: rtl/rd_wait_responder_pkg.sv
// ---------------------------------------------------------------------------
// rd_resp_pkg : shared types and constants for rd_wait_responder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rd_resp_pkg;

    localparam int CNT_W      = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        READY = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rd_wait_responder_if.sv
// ---------------------------------------------------------------------------
// rd_wait_responder_if : rd/ws/ds handshake plus storage write port
// Rev 1.0   (rpar present when RESP_PARITY_EN is defined)
// ---------------------------------------------------------------------------
`default_nettype none

interface rd_wait_responder_if #(
    parameter int DATA_W = rd_resp_pkg::DEF_DATA_W,
    parameter int ADDR_W = rd_resp_pkg::DEF_ADDR_W
);
    logic              rd;
    logic              ds;
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              ws;
    logic [DATA_W-1:0] rdata;
    logic              busy;
`ifdef RESP_PARITY_EN
    logic              rpar;
`endif

    modport master (
        output rd, ds, addr, wr_en, waddr, wdata,
        input  ws, rdata, busy
`ifdef RESP_PARITY_EN
        , input rpar
`endif
    );

    modport slave (
        input  rd, ds, addr, wr_en, waddr, wdata,
        output ws, rdata, busy
`ifdef RESP_PARITY_EN
        , output rpar
`endif
    );
endinterface

`default_nettype wire

// File: rtl/rd_resp_mem.sv
// ---------------------------------------------------------------------------
// rd_resp_mem : synchronous-write register array, read value sampled by owner
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rd_resp_mem
    import rd_resp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  wire logic              clk,
    input  wire logic              wr_en,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [ADDR_W-1:0] raddr,
    output logic      [DATA_W-1:0] rd_val
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // The owner registers rd_val on the same edge a write may land, so it
    // always sees the pre-write contents (read-before-write).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rd_val = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/rd_wait_responder.sv
// ---------------------------------------------------------------------------
// rd_wait_responder : target-side rd/ws/ds responder with fixed wait states
// Rev 1.0   (optional rpar output via RESP_PARITY_EN)
// ---------------------------------------------------------------------------
`default_nettype none

module rd_wait_responder
    import rd_resp_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_CYCLES = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    rd_wait_responder_if.slave bus
);

    localparam logic             c_WS_IDLE   = (WAIT_CYCLES > 0);
    localparam logic [CNT_W-1:0] c_CNT_INIT  = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_wait
        $error("rd_wait_responder: WAIT_CYCLES must be in 0..15");
    end
    if (($bits(bus.rdata) != DATA_W) || ($bits(bus.addr) != ADDR_W)) begin : g_bad_if
        $error("rd_wait_responder: interface widths do not match parameters");
    end

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr_q;
    logic                r_ws;
    logic                r_busy;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   w_raddr;
    logic [DATA_W-1:0]   w_rd_val;

    // Zero-wait accesses read straight from the live address in IDLE.
    assign w_raddr = (r_state == IDLE) ? bus.addr : r_addr_q;

    rd_resp_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .wr_en  (bus.wr_en),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata),
        .raddr  (w_raddr),
        .rd_val (w_rd_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr_q <= '0;
            r_ws     <= c_WS_IDLE;
            r_busy   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.rd) begin
                        r_addr_q <= bus.addr;
                        r_busy   <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= WAIT;
                            r_cnt   <= c_CNT_INIT;
                            r_ws    <= 1'b1;
                        end else begin
                            r_state <= READY;
                            r_ws    <= 1'b0;
                            r_rdata <= w_rd_val;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.rd) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_ws    <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_cnt > c_CNT_ONE) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else begin
                        r_state <= READY;
                        r_cnt   <= '0;
                        r_ws    <= 1'b0;
                        r_rdata <= w_rd_val;
                    end
                end
                READY: begin
                    // ds takes priority over a still-high rd; re-accept needs IDLE.
                    if (bus.ds || !bus.rd) begin
                        r_state <= IDLE;
                        r_ws    <= c_WS_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_ws    <= c_WS_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ws    = r_ws;
    assign bus.busy  = r_busy;
    assign bus.rdata = r_rdata;

`ifdef RESP_PARITY_EN
    logic r_rpar;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rpar <= 1'b0;
        end else if (((r_state == IDLE) && bus.rd && (WAIT_CYCLES == 0)) ||
                     ((r_state == WAIT) && bus.rd && (r_cnt <= c_CNT_ONE))) begin
            r_rpar <= ^w_rd_val;
        end
    end

    assign bus.rpar = r_rpar;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rd_wait_responder.sv
// ---------------------------------------------------------------------------
// tb_rd_wait_responder : scoreboard bench, one DUT with 3 wait states, one with 0
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rd_wait_responder;

    localparam int WAIT3 = 3;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    logic [7:0] sb3[$];
    logic [7:0] sb0[$];
    logic [7:0] last3;

    always #5 clk = ~clk;

    rd_wait_responder_if #(.DATA_W(8), .ADDR_W(4)) bus3();
    rd_wait_responder_if #(.DATA_W(8), .ADDR_W(4)) bus0();

    rd_wait_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(WAIT3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    rd_wait_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    task automatic write3(input logic [3:0] a, input logic [7:0] d);
        bus3.wr_en = 1'b1; bus3.waddr = a; bus3.wdata = d;
        @(posedge clk); #1;
        bus3.wr_en = 1'b0;
    endtask

    task automatic write0(input logic [3:0] a, input logic [7:0] d);
        bus0.wr_en = 1'b1; bus0.waddr = a; bus0.wdata = d;
        @(posedge clk); #1;
        bus0.wr_en = 1'b0;
    endtask

    // Drives an access on dut3 until ws falls; optional write collides with capture.
    task automatic read3(input logic [3:0] a, input logic [7:0] exp,
                         input bit coll, input logic [7:0] cdata);
        int         n;
        bit         done;
        logic [7:0] e;
        sb3.push_back(exp);
        bus3.rd = 1'b1; bus3.addr = a;
        n = 0; done = 1'b0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (coll && n == WAIT3) begin
                bus3.wr_en = 1'b1; bus3.waddr = a; bus3.wdata = cdata;
            end else begin
                bus3.wr_en = 1'b0;
            end
            if (bus3.ws === 1'b0) done = 1'b1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL read3_timeout addr=%0d: ws never fell within %0d edges", a, n);
        end else if (n !== WAIT3 + 1) begin
            fails++;
            $display("FAIL read3_latency addr=%0d: got %0d edges incl accept, want %0d", a, n, WAIT3 + 1);
        end
        e = (sb3.size() > 0) ? sb3.pop_front() : 8'hxx;
        tests++;
        if (bus3.rdata !== e) begin
            fails++;
            $display("FAIL read3_rdata addr=%0d: got %h want %h", a, bus3.rdata, e);
        end
        tests++;
        if (bus3.busy !== 1'b1) begin
            fails++;
            $display("FAIL read3_busy addr=%0d: got %b want 1", a, bus3.busy);
        end
`ifdef RESP_PARITY_EN
        tests++;
        if (bus3.rpar !== ^e) begin
            fails++;
            $display("FAIL read3_rpar addr=%0d: got %b want %b", a, bus3.rpar, ^e);
        end
`endif
        last3 = e;
    endtask

    // ds pulse out of READY on dut3; hold_rd keeps rd high to exercise ds priority.
    task automatic finish3(input bit hold_rd);
        bus3.ds = 1'b1; bus3.rd = hold_rd;
        @(posedge clk); #1;
        bus3.ds = 1'b0;
        tests++;
        if (bus3.ws !== 1'b1 || bus3.busy !== 1'b0 || bus3.rdata !== last3) begin
            fails++;
            $display("FAIL finish3: ws=%b busy=%b rdata=%h want ws=1 busy=0 rdata=%h",
                     bus3.ws, bus3.busy, bus3.rdata, last3);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus3.rd = 0; bus3.ds = 0; bus3.addr = 0; bus3.wr_en = 0; bus3.waddr = 0; bus3.wdata = 0;
        bus0.rd = 0; bus0.ds = 0; bus0.addr = 0; bus0.wr_en = 0; bus0.waddr = 0; bus0.wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus3.ws !== 1'b1 || bus3.busy !== 1'b0 || bus3.rdata !== 8'h00) begin
            fails++;
            $display("FAIL reset_dut3: ws=%b busy=%b rdata=%h want 1 0 00", bus3.ws, bus3.busy, bus3.rdata);
        end
        tests++;
        if (bus0.ws !== 1'b0 || bus0.busy !== 1'b0 || bus0.rdata !== 8'h00) begin
            fails++;
            $display("FAIL reset_dut0: ws=%b busy=%b rdata=%h want 0 0 00", bus0.ws, bus0.busy, bus0.rdata);
        end
`ifdef RESP_PARITY_EN
        tests++;
        if (bus3.rpar !== 1'b0) begin
            fails++;
            $display("FAIL reset_rpar: got %b want 0", bus3.rpar);
        end
`endif
        rst = 1'b0;
        last3 = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (bus3.ws !== 1'b1 || bus3.busy !== 1'b0 || bus3.rdata !== 8'h00 ||
                bus0.ws !== 1'b0 || bus0.busy !== 1'b0) begin
                fails++;
                $display("FAIL idle_hold cycle %0d: ws3=%b busy3=%b rdata3=%h ws0=%b busy0=%b",
                         i, bus3.ws, bus3.busy, bus3.rdata, bus0.ws, bus0.busy);
            end
        end
    endtask

    task automatic test_wait_read;
        write3(4'd5, 8'hA5);
        read3(4'd5, 8'hA5, 1'b0, 8'h00);
        finish3(1'b0);
    endtask

    task automatic test_zero_wait;
        logic [7:0] e;
        write0(4'd2, 8'h3C);
        tests++;
        if (bus0.ws !== 1'b0) begin
            fails++;
            $display("FAIL zw_idle_ws: got %b want 0", bus0.ws);
        end
        sb0.push_back(8'h3C);
        bus0.rd = 1'b1; bus0.addr = 4'd2;
        @(posedge clk); #1;
        e = (sb0.size() > 0) ? sb0.pop_front() : 8'hxx;
        tests++;
        if (bus0.ws !== 1'b0 || bus0.busy !== 1'b1 || bus0.rdata !== e) begin
            fails++;
            $display("FAIL zw_ready: ws=%b busy=%b rdata=%h want 0 1 %h", bus0.ws, bus0.busy, bus0.rdata, e);
        end
        bus0.ds = 1'b1; bus0.rd = 1'b0;
        @(posedge clk); #1;
        bus0.ds = 1'b0;
        tests++;
        if (bus0.ws !== 1'b0 || bus0.busy !== 1'b0 || bus0.rdata !== e) begin
            fails++;
            $display("FAIL zw_done: ws=%b busy=%b rdata=%h want 0 0 %h", bus0.ws, bus0.busy, bus0.rdata, e);
        end
    endtask

    task automatic test_abort;
        write3(4'd2, 8'h5A);
        bus3.rd = 1'b1; bus3.addr = 4'd2;
        @(posedge clk); #1;
        bus3.ds = 1'b1;
        @(posedge clk); #1;
        bus3.ds = 1'b0;
        tests++;
        if (bus3.ws !== 1'b1 || bus3.busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_ds_in_wait: ws=%b busy=%b want 1 1", bus3.ws, bus3.busy);
        end
        bus3.rd = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (bus3.ws !== 1'b1 || bus3.busy !== 1'b0 || bus3.rdata !== last3) begin
            fails++;
            $display("FAIL abort_idle: ws=%b busy=%b rdata=%h want 1 0 %h", bus3.ws, bus3.busy, bus3.rdata, last3);
        end
        read3(4'd5, 8'hA5, 1'b0, 8'h00);
        finish3(1'b0);
    endtask

    task automatic test_collision;
        write3(4'd7, 8'h22);
        read3(4'd7, 8'h22, 1'b1, 8'h11);
        finish3(1'b0);
        read3(4'd7, 8'h11, 1'b0, 8'h00);
        finish3(1'b0);
    endtask

    task automatic test_back_to_back;
        read3(4'd5, 8'hA5, 1'b0, 8'h00);
        finish3(1'b1);
        @(posedge clk); #1;
        tests++;
        if (bus3.busy !== 1'b1 || bus3.ws !== 1'b1) begin
            fails++;
            $display("FAIL b2b_reaccept: busy=%b ws=%b want 1 1", bus3.busy, bus3.ws);
        end
        bus3.rd = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (bus3.busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_abort: busy=%b want 0", bus3.busy);
        end
    endtask

    task automatic test_parity_data;
        write3(4'd3, 8'h07);
        read3(4'd3, 8'h07, 1'b0, 8'h00);
        finish3(1'b0);
    endtask

    task automatic test_rst_mid;
        read3(4'd5, 8'hA5, 1'b0, 8'h00);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (bus3.ws !== 1'b1 || bus3.busy !== 1'b0 || bus3.rdata !== 8'h00) begin
            fails++;
            $display("FAIL rst_mid: ws=%b busy=%b rdata=%h want 1 0 00", bus3.ws, bus3.busy, bus3.rdata);
        end
`ifdef RESP_PARITY_EN
        tests++;
        if (bus3.rpar !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_rpar: got %b want 0", bus3.rpar);
        end
`endif
        bus3.rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last3 = 8'h00;
    endtask

    initial begin
        test_reset;
        test_wait_read;
        test_zero_wait;
        test_abort;
        test_collision;
        test_back_to_back;
        test_parity_data;
        test_rst_mid;
        tests++;
        if (sb3.size() != 0 || sb0.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: sb3=%0d sb0=%0d entries left, want 0", sb3.size(), sb0.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
